// File: rtl/imem_ctrl.sv
// Instruction-memory controller between fetch_unit and a req/gnt/rvalid memory bus.
// Handles one outstanding fetch, jump flushes, misaligned addresses and response timeouts.
module imem_ctrl #(
    parameter int               nbits   = 32,
    parameter int               TIMEOUT = 16,
    parameter logic [nbits-1:0] NOP     = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             proc_req,
    input  logic [nbits-1:0] Add,
    input  logic             j,
    output logic             mem_ready,
    output logic             valid,
    output logic [nbits-1:0] Rdata,
    output logic             err,
    output logic             mem_req,
    output logic [nbits-1:0] mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [nbits-1:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

    state_t        state;
    logic          valid_q;
    logic          err_q;
    logic          drop;
    logic [CW-1:0] cnt;

    assign mem_ready = (state == IDLE);
    assign valid     = valid_q & ~j;
    assign err       = err_q;

    // A jump seen anywhere in REQ/RESP (including the response cycle itself) discards the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            Rdata    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            drop     <= 1'b0;
            cnt      <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (proc_req) begin
                        if (Add[1:0] != 2'b00) begin
                            Rdata   <= NOP;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            mem_addr <= {Add[nbits-1:2], 2'b00};
                            mem_req  <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (j)
                        drop <= 1'b1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        if (!(drop || j)) begin
                            Rdata   <= mem_rdata;
                            valid_q <= 1'b1;
                        end
                        drop  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        if (!(drop || j)) begin
                            Rdata   <= NOP;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                        end
                        drop  <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (j)
                            drop <= 1'b1;
                    end
                end
                DRAIN: begin
                    // The late response still owns the bus; swallow it before taking new work.
                    if (mem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
